// File: rtl/sa_feed_ctrl.sv
// sa_feed_ctrl: sequences one shared load pulse followed by a diagonally
// skewed read schedule across the serializer bank, then a drain interval
// and a one-cycle completion pulse.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; ready=1
//   LOAD   | single write_enable pulse to every serializer
//   STREAM | issuing skewed read steps t = 0 .. LANES+DEPTH-2
//   DRAIN  | flush interval, d = 0 .. DRAIN-1
//   DONE   | single done pulse, then back to IDLE
//
// All outputs are registered. The value presented in a cycle is decided at
// the edge that opens it, using the stall level sampled at that edge. A
// stalled cycle issues nothing and holds t/d. The edge leaving LOAD always
// issues step 0, so stall has no effect in IDLE or LOAD.
module sa_feed_ctrl #(
  parameter int LANES = 32,
  parameter int DEPTH = 32,
  parameter int DRAIN = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             ready,
  output logic             busy,
  output logic             write_enable,
  output logic [LANES-1:0] read_enable,
  output logic             done
);

  localparam int TW = $clog2(LANES + DEPTH);
  localparam int DW = $clog2(DRAIN + 1);

  localparam logic [TW-1:0] T_LAST = TW'(LANES + DEPTH - 2);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic [TW-1:0] t;
  logic [DW-1:0] d;
  logic [TW-1:0] t_inc;

  // Lane i shifts on steps i .. i+DEPTH-1 (diagonal wavefront).
  function automatic logic [LANES-1:0] lane_mask(input logic [TW-1:0] step);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (int'(step) >= i) && (int'(step) <= i + DEPTH - 1);
    end
    return m;
  endfunction

  // Next step index while streaming.
  always_comb begin
    t_inc = t + 1'b1;
  end

  // Sequencer: state, step/drain counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      t            <= '0;
      d            <= '0;
      write_enable <= 1'b0;
      read_enable  <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      ready        <= 1'b1;
    end else begin
      write_enable <= 1'b0;
      read_enable  <= '0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LOAD;
            write_enable <= 1'b1;
            busy         <= 1'b1;
            ready        <= 1'b0;
          end
        end
        S_LOAD: begin
          state       <= S_STREAM;
          t           <= '0;
          read_enable <= lane_mask('0);
        end
        S_STREAM: begin
          if (!stall) begin
            if (t == T_LAST) begin
              state <= S_DRAIN;
              d     <= '0;
            end else begin
              t           <= t_inc;
              read_enable <= lane_mask(t_inc);
            end
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            if (d == D_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              d <= d + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          t     <= '0;
          d     <= '0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          t     <= '0;
          d     <= '0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Bench for sa_feed_ctrl: a small instance (4/4/3) exercised with directed
// and randomized stall/start patterns against a progress-count model, plus
// a default-parameter instance checked against the headline timing numbers.
// Cycle k is the k-th cycle after the edge that samples start; stall_at[k]
// is the stall level sampled at the edge that opens cycle k.
module tb_sa_feed_ctrl;

  localparam int L    = 4;
  localparam int D    = 4;
  localparam int DR   = 3;
  localparam int LD1  = L + D - 1;
  localparam int MAXC = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, stall;
  logic         ready, busy, we, done;
  logic [L-1:0] re;

  logic         start_d, stall_d;
  logic         ready_d, busy_d, we_d, done_d;
  logic [31:0]  re_d;

  int checks = 0;
  int errors = 0;

  bit           stall_at    [MAXC];
  bit           start_noise [MAXC];
  logic [L+3:0] exp_o       [MAXC];
  logic [L-1:0] re_log      [MAXC];
  logic         done_log    [MAXC];
  int           kend;

  sa_feed_ctrl #(.LANES(L), .DEPTH(D), .DRAIN(DR)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .ready(ready), .busy(busy), .write_enable(we),
    .read_enable(re), .done(done)
  );

  sa_feed_ctrl dut_def (
    .clk(clk), .rst(rst), .start(start_d), .stall(stall_d),
    .ready(ready_d), .busy(busy_d), .write_enable(we_d),
    .read_enable(re_d), .done(done_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Load and read must never coincide on either instance.
  always @(negedge clk) begin
    check("excl_small", {63'd0, we & (|re)}, 64'd0);
    assert (!(we_d && (|re_d)));
  end

  function automatic logic [L-1:0] ref_mask(input int s);
    logic [L-1:0] m;
    for (int i = 0; i < L; i++) m[i] = (s >= i) && (s <= i + D - 1);
    return m;
  endfunction

  // Expected {ready,busy,we,done,re} per cycle: cycle 1 loads, cycle 2 is
  // always progress step 0, later cycles advance one progress step unless
  // stalled. Steps 0..LD1-1 read, the next DR steps drain, the step after
  // that is the done cycle.
  task automatic build_model();
    int s;
    for (int k = 0; k < MAXC; k++) exp_o[k] = '0;
    kend = -1;
    exp_o[1] = {1'b0, 1'b1, 1'b1, 1'b0, {L{1'b0}}};
    exp_o[2] = {1'b0, 1'b1, 1'b0, 1'b0, ref_mask(0)};
    s = 0;
    for (int k = 3; k < MAXC - 2; k++) begin
      if (stall_at[k]) begin
        exp_o[k] = {1'b0, 1'b1, 1'b0, 1'b0, {L{1'b0}}};
      end else begin
        s++;
        if (s == LD1 + DR) begin
          exp_o[k] = {1'b0, 1'b1, 1'b0, 1'b1, {L{1'b0}}};
          kend = k;
          break;
        end
        exp_o[k] = {1'b0, 1'b1, 1'b0, 1'b0, (s < LD1) ? ref_mask(s) : {L{1'b0}}};
      end
    end
    if (kend > 0) exp_o[kend + 1] = {1'b1, 1'b0, 1'b0, 1'b0, {L{1'b0}}};
  endtask

  task automatic clear_pattern();
    for (int k = 0; k < MAXC; k++) begin
      stall_at[k]    = 1'b0;
      start_noise[k] = 1'b0;
      re_log[k]      = '0;
      done_log[k]    = 1'b0;
    end
  endtask

  // Runs one job on the small instance; entered and left 1 time unit after
  // an edge with the controller idle.
  task automatic run_job(input string name);
    int cnt [L];
    build_model();
    if (kend < 0) begin
      check({name, "_model_bound"}, 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < L; i++) cnt[i] = 0;
    stall = stall_at[1];
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= kend + 1; k++) begin
      #1;
      re_log[k]   = re;
      done_log[k] = done;
      check($sformatf("%s_c%0d", name, k), {ready, busy, we, done, re}, exp_o[k]);
      for (int i = 0; i < L; i++) cnt[i] += int'(re[i]);
      start = (k <= kend) ? start_noise[k] : 1'b0;
      stall = stall_at[k + 1];
      if (k <= kend) @(posedge clk);
    end
    start = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < L; i++) check($sformatf("%s_pulses_l%0d", name, i), cnt[i], D);
  endtask

  initial begin
    int first31, last31, done_cyc;
    int cnt_d [32];
    rst = 1'b1; start = 1'b0; stall = 1'b0; start_d = 1'b0; stall_d = 1'b0;
    clear_pattern();
    repeat (2) @(posedge clk);
    #1;
    check("reset_small", {ready, busy, we, done, re}, {1'b1, 1'b0, 1'b0, 1'b0, {L{1'b0}}});
    check("reset_def", {ready_d, busy_d, we_d, done_d, re_d}, {1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal schedule.
    clear_pattern();
    run_job("nom");
    check("nom_re_c2", re_log[2], 4'b0001);
    check("nom_re_c3", re_log[3], 4'b0011);
    check("nom_re_c5", re_log[5], 4'b1111);
    check("nom_re_c6", re_log[6], 4'b1110);
    check("nom_re_c8", re_log[8], 4'b1000);
    check("nom_re_c9", re_log[9], 4'b0000);
    check("nom_done_c12", done_log[12], 1'b1);

    // Stall in cycles 4-5 of the stream.
    clear_pattern();
    stall_at[4] = 1'b1; stall_at[5] = 1'b1;
    run_job("stl");
    check("stl_re_c4", re_log[4], 4'b0000);
    check("stl_re_c5", re_log[5], 4'b0000);
    check("stl_re_c6", re_log[6], 4'b0111);
    check("stl_done_c14", done_log[14], 1'b1);

    // Stall during IDLE and LOAD has no effect.
    clear_pattern();
    stall_at[1] = 1'b1; stall_at[2] = 1'b1;
    run_job("stl_il");
    check("stl_il_done_c12", done_log[12], 1'b1);

    // 100 stalled drain cycles.
    clear_pattern();
    for (int k = 9; k < 109; k++) stall_at[k] = 1'b1;
    run_job("drn");
    check("drn_done_c112", done_log[112], 1'b1);

    // Start held high: loads land every 13 cycles.
    clear_pattern();
    start = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("cont_we_c%0d", k), we, (k % 13 == 1) ? 1'b1 : 1'b0);
    end
    start = 1'b0;
    begin
      int n;
      for (n = 0; n < 50; n++) begin
        if (ready) break;
        @(posedge clk);
        #1;
      end
      check("cont_idle", ready, 1'b1);
    end

    // Asynchronous reset in the middle of cycle 6.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_pre_c6", re, 4'b1110);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", {ready, busy, we, done, re}, {1'b1, 1'b0, 1'b0, 1'b0, {L{1'b0}}});
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_pattern();
    run_job("post_rst");

    // Randomized stall and spurious-start patterns.
    for (int j = 0; j < 15; j++) begin
      int pct;
      clear_pattern();
      pct = $urandom_range(0, 60);
      for (int k = 1; k < 60; k++) stall_at[k] = ($urandom_range(0, 99) < pct);
      for (int k = 0; k < MAXC; k++) start_noise[k] = $urandom_range(0, 1) == 1;
      run_job($sformatf("rnd%0d", j));
    end

    // Default-parameter instance: headline timing.
    for (int i = 0; i < 32; i++) cnt_d[i] = 0;
    first31 = -1; last31 = -1; done_cyc = -1;
    start_d = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 120; k++) begin
      #1;
      if (k == 1) check("def_we_c1", we_d, 1'b1);
      for (int i = 0; i < 32; i++) cnt_d[i] += int'(re_d[i]);
      if (re_d[31]) begin
        if (first31 < 0) first31 = k;
        last31 = k;
      end
      if (done_d && done_cyc < 0) done_cyc = k;
      start_d = 1'b0;
      @(posedge clk);
    end
    #1;
    check("def_lane31_first", first31, 33);
    check("def_lane31_last", last31, 64);
    check("def_done_c105", done_cyc, 105);
    check("def_ready_end", ready_d, 1'b1);
    for (int i = 0; i < 32; i++) check($sformatf("def_pulses_l%0d", i), cnt_d[i], 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_feed_ctrl.md
# sa_feed_ctrl

Sequencing controller for the operand serializer bank that feeds the systolic array. On each start it issues one shared load pulse to every serializer, then drives per-lane read enables in a diagonal skew (lane i starts i cycles after lane 0), so operands enter the array wavefront-aligned. It then waits a drain interval for the array to flush and reports completion. One instance drives the full serializer bank: A-side and B-side lanes share the same schedule.

## Interface
- `LANES`, default 32: number of serializer lanes driven, i.e. the skew span.
- `DEPTH`, default 32: elements held per serializer, i.e. the read pulses per lane.
- `DRAIN`, default 40: flush cycles after the last read; must be ≥ 1.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: request one load+stream job; sampled only in IDLE.
- `stall` in, 1: freeze streaming and drain progress while high.
- `ready` out, 1: high in IDLE; the job can be accepted.
- `busy` out, 1: high in LOAD, STREAM, DRAIN and DONE.
- `write_enable` out, 1: load pulse to all serializers.
- `read_enable` out, LANES: per-lane shift enable; bit i goes to lane i.
- `done` out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, DONE. All outputs are registered.
- Reset (async, any state): state=IDLE, all counters 0, `write_enable`=0, `read_enable`=0, `done`=0, `busy`=0, `ready`=1.
- IDLE: when `start`=1, go to LOAD. `stall` is ignored.
- LOAD: lasts exactly 1 cycle. `write_enable`=1, `read_enable`=0. Next state is STREAM with t=0. `stall` is ignored in LOAD.
- STREAM: step counter t runs from 0 to LANES+DEPTH-2. Its width is $clog2(LANES+DEPTH).
  - `read_enable[i]` = 1 iff i ≤ t ≤ i+DEPTH-1 and `stall`=0.
  - After t = LANES+DEPTH-2 is issued, go to DRAIN with d=0.
- DRAIN: d counts from 0 to DRAIN-1; `read_enable`=0. After d = DRAIN-1, go to DONE.
- DONE: lasts exactly 1 cycle with `done`=1, then go to IDLE.
- Stall: while `stall`=1 in STREAM or DRAIN:
  - t and d hold and all `read_enable` bits are 0.
  - On release, the schedule resumes at the held count. No pulse is lost or duplicated.
- Invariants:
  - `write_enable` and any `read_enable` bit are never high in the same cycle. The serializer treats both-high as hold.
  - Each lane receives exactly DEPTH read pulses per job, in DEPTH contiguous non-stalled steps.
  - `start` while busy is ignored. It is not queued.
  - `start` in the DONE cycle is ignored; the job is accepted from IDLE in the following cycle.

## Timing
- Let E0 be the edge at which `start`=1 is sampled in IDLE. Cycle k is the cycle after edge E0+k.
- Cycle 1: `write_enable`=1, `ready`=0, `busy`=1.
- Cycles 2 … LANES+DEPTH: STREAM. Lane i is read in cycles 2+i … 1+i+DEPTH.
- Cycles LANES+DEPTH+1 … LANES+DEPTH+DRAIN: DRAIN.
- Cycle LANES+DEPTH+DRAIN+1: `done`=1.
- Next cycle: IDLE, `ready`=1.
- Job latency with no stalls is LANES+DEPTH+DRAIN+1 cycles from start to done. Each stalled cycle in STREAM or DRAIN adds exactly 1 cycle.
- Back-to-back: the earliest next start is sampled in the first IDLE cycle, so there is a 1-cycle gap between `done` and the next `write_enable`.
- Reset mid-job: outputs drop combinationally-async to reset values. A partially shifted serializer bank is the host's concern; the next job reloads it.

## Test plan
- Cfg LANES=4, DEPTH=4, DRAIN=3; start pulse at cycle 0:
  - `write_enable` is high in cycle 1 only.
  - `read_enable` is 0001 in c2, 0011 in c3, 0111 in c4, 1111 in c5, 1110 in c6, 1100 in c7, 1000 in c8, then 0 in c9–c11.
  - `done` is high in c12 and `ready` is high in c13.
- Same cfg, `stall` high in cycles 4–5: `read_enable` is 0 in c4–c5, and the c4 pattern (0111) appears in c6. `done` moves to c14. Every lane still counts exactly 4 pulses.
- `start` held high continuously: jobs repeat with `write_enable` in c1, c14, c27, …. `start` during busy or DONE never creates an extra load.
- Assert `rst` in cycle 6 of a job, asynchronous mid-cycle: all outputs are 0 and `ready`=1 before the next edge. A start after release runs a full, correct schedule.
- Defaults (32, 32, 40): the per-lane pulse count is 32. Lane 31's first read is in c33 and its last in c64. `done` is in c105. `write_enable` and `read_enable` are never simultaneously high, checked by assertion.
- `stall` held high in IDLE and LOAD: no effect on timing. `stall` held for 100 cycles in DRAIN: `done` is delayed by exactly 100 cycles.
